// File: rtl/bmu_pipe.sv
// bmu_pipe: two-stage bit-manipulation unit with valid/ready flow control,
// flush, and a saturating count of errored results handed downstream.
module bmu_pipe #(
  parameter  int XLEN  = 32,
  parameter  int CNT_W = 8,
  localparam int SHW   = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  a_in,
  input  logic [XLEN-1:0]  b_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             error,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ANDN = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_BEXT = 4'd7,
    OP_SLT  = 4'd8,
    OP_MIN  = 4'd9,
    OP_CLZ  = 4'd10,
    OP_CPOP = 4'd11
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            err;
  } pl_t;

  logic            s1_v_q, s1_v_d;
  logic            s2_v_q, s2_v_d;
  pl_t             s1_q, s1_d;
  pl_t             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            s1_ready, s2_ready;
  logic            accept, deliver;
  pl_t             calc;

  logic [XLEN:0]   sum_w, dif_w;
  logic [SHW-1:0]  sh;
  logic            lt_w;
  logic [XLEN-1:0] clz_w, cpop_w;
  logic            found;

  assign s2_ready = !s2_v_q | out_ready;
  assign s1_ready = !s1_v_q | s2_ready;
  assign in_ready = s1_ready & !flush;
  assign accept   = in_valid & in_ready;
  assign deliver  = s2_v_q & out_ready;

  // Overflow shows up as disagreement between the two top sum bits.
  assign sum_w = {a_in[XLEN-1], a_in} + {b_in[XLEN-1], b_in};
  assign dif_w = {a_in[XLEN-1], a_in} - {b_in[XLEN-1], b_in};
  assign sh    = b_in[SHW-1:0];
  assign lt_w  = $signed(a_in) < $signed(b_in);

  always_comb begin
    clz_w = '0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found) begin
        if (a_in[i]) found = 1'b1;
        else         clz_w = clz_w + XLEN'(1);
      end
    end
  end

  always_comb begin
    cpop_w = '0;
    for (int i = 0; i < XLEN; i++) begin
      cpop_w = cpop_w + XLEN'(a_in[i]);
    end
  end

  always_comb begin
    calc = '0;
    unique case (op)
      OP_ADD: begin
        calc.res = sum_w[XLEN-1:0];
        calc.err = sum_w[XLEN] ^ sum_w[XLEN-1];
      end
      OP_SUB: begin
        calc.res = dif_w[XLEN-1:0];
        calc.err = dif_w[XLEN] ^ dif_w[XLEN-1];
      end
      OP_AND:  calc.res = a_in & b_in;
      OP_ANDN: calc.res = a_in & ~b_in;
      OP_XOR:  calc.res = a_in ^ b_in;
      OP_SLL:  calc.res = a_in << sh;
      OP_SRA:  calc.res = $signed(a_in) >>> sh;
      OP_BEXT: calc.res = XLEN'(a_in[sh]);
      OP_SLT:  calc.res = XLEN'(lt_w);
      OP_MIN:  calc.res = lt_w ? a_in : b_in;
      OP_CLZ:  calc.res = clz_w;
      OP_CPOP: calc.res = cpop_w;
      default: calc.err = 1'b1;
    endcase
  end

  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    s2_v_d = s2_v_q;
    s2_d   = s2_q;
    if (s1_ready) s1_v_d = accept;
    if (accept)   s1_d   = calc;
    if (s2_ready) s2_v_d = s1_v_q;
    if (s2_ready && s1_v_q && !flush) s2_d = s1_q;
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if (deliver && s2_q.err && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign result    = s2_q.res;
  assign error     = s2_q.err;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_bmu_pipe.sv
// tb_bmu_pipe: directed scoreboard bench for bmu_pipe, 32-bit instance with
// a 2-bit error counter plus a 64-bit instance for wide-operand cases.
module tb_bmu_pipe;

  typedef struct {
    logic [31:0] r;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        error;
  logic        err_clr = 1'b0;
  logic [1:0]  err_cnt;

  logic        w_iv = 1'b0;
  logic        w_ir;
  logic [3:0]  w_op = 4'd0;
  logic [63:0] w_a = '0;
  logic [63:0] w_b = '0;
  logic        w_ov;
  logic [63:0] w_res;
  logic        w_err;
  logic [7:0]  w_cnt;

  int          nvec = 0;
  int          nmis = 0;
  exp_t        q[$];
  exp_t        pend;
  logic        acc;

  bmu_pipe #(.XLEN(32), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .error     (error),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  bmu_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (w_iv),
    .in_ready  (w_ir),
    .op        (w_op),
    .a_in      (w_a),
    .b_in      (w_b),
    .flush     (1'b0),
    .out_valid (w_ov),
    .out_ready (1'b1),
    .result    (w_res),
    .error     (w_err),
    .err_clr   (1'b0),
    .err_cnt   (w_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endfunction

  // Pop on delivery first, then record a newly accepted op.
  always @(negedge clk) begin
    if (rst_l) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'd0);
        end else if (out_ready) begin
          exp_t x;
          x = q.pop_front();
          chk("sb_result", 64'(result), 64'(x.r));
          chk("sb_error", 64'(error), 64'(x.e));
        end
      end
      if (in_valid && in_ready) q.push_back(pend);
    end
  end

  task automatic tick();
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er,
                       input logic ee);
    op = o;
    a_in = a;
    b_in = b;
    pend.r = er;
    pend.e = ee;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) tick();
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er,
                      input logic ee);
    drive(o, a, b, er, ee);
    wait_accept();
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (q.size() != 0 || out_valid); k++) tick();
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    chk("wait_out", 64'(out_valid), 64'd1);
  endtask

  task automatic run64(input logic [3:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] er,
                       input logic ee, input string tag);
    logic got;
    got = 1'b0;
    w_op = o;
    w_a = a;
    w_b = b;
    w_iv = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = w_ir;
      @(posedge clk);
      #1;
    end
    w_iv = 1'b0;
    for (int k = 0; k < 20 && !w_ov; k++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, 64'(w_ov), 64'd1);
    chk({tag, "_res"}, w_res, er);
    chk({tag, "_err"}, 64'(w_err), 64'(ee));
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_l = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Overflowing add, with a look at when the result first shows up.
    send(4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
    chk("lat_accept_edge", 64'(out_valid), 64'd0);
    tick();
    chk("lat_next_edge", 64'(out_valid), 64'd1);
    drain();
    chk("cnt_after_add", 64'(err_cnt), 64'd1);
    send(4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1);
    drain();
    chk("cnt_after_sub", 64'(err_cnt), 64'd2);

    // Back-to-back stream with a three-cycle downstream stall.
    send(4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
    send(4'd5, 32'd1, 32'd31, 32'h80000000, 1'b0);
    out_ready = 1'b0;
    chk("stream_first_out", 64'(out_valid), 64'd1);
    drive(4'd6, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_in_ready", 64'(acc), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'(result), 64'h0FF00FF0);
    end
    out_ready = 1'b1;
    wait_accept();
    send(4'd7, 32'h8, 32'd3, 32'h1, 1'b0);
    drain();

    // Assorted single ops.
    send(4'd10, 32'h0, 32'h0, 32'd32, 1'b0);
    send(4'd10, 32'h00010000, 32'h0, 32'd15, 1'b0);
    send(4'd11, 32'hF0F0F0F0, 32'h0, 32'd16, 1'b0);
    send(4'd9, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFFB, 1'b0);
    send(4'd9, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFB, 1'b0);
    send(4'd8, 32'hFFFFFFFF, 32'h0, 32'd1, 1'b0);
    send(4'd8, 32'h0, 32'hFFFFFFFF, 32'd0, 1'b0);
    send(4'd2, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0);
    send(4'd3, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0);
    send(4'd5, 32'd1, 32'd33, 32'd2, 1'b0);
    send(4'd0, 32'd5, 32'hFFFFFFFD, 32'd2, 1'b0);
    send(4'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
    send(4'd13, 32'h12345678, 32'h9, 32'd0, 1'b1);
    drain();
    chk("cnt_sat_early", 64'(err_cnt), 64'd3);

    // Saturation from zero, then clear racing a delivery.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("cnt_cleared", 64'(err_cnt), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      send(4'(12 + (k % 4)), 32'hA5A5A5A5, 32'h1, 32'd0, 1'b1);
      drain();
      chk("cnt_sat", 64'(err_cnt), (k < 3) ? 64'(k) : 64'd3);
    end
    out_ready = 1'b0;
    send(4'd13, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_out();
    chk("cnt_before_clr", 64'(err_cnt), 64'd3);
    out_ready = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("cnt_clr_wins", 64'(err_cnt), 64'd0);
    drain();

    // Flush with two ops in flight and a third offered.
    out_ready = 1'b0;
    send(4'd0, 32'd1, 32'd2, 32'd3, 1'b0);
    send(4'd13, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    drive(4'd4, 32'h1, 32'h2, 32'h3, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_no_accept", 64'(acc), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush_stays_empty", 64'(out_valid), 64'd0);
    chk("flush_cnt", 64'(err_cnt), 64'd0);

    // Asynchronous reset while a result is stalled at the output.
    send(4'd12, 32'd0, 32'd0, 32'd0, 1'b1);
    drain();
    chk("cnt_pre_reset", 64'(err_cnt), 64'd1);
    out_ready = 1'b0;
    send(4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
    wait_out();
    #2;
    rst_l = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_error", 64'(error), 64'd0);
    chk("arst_err_cnt", 64'(err_cnt), 64'd0);
    q.delete();
    #10;
    rst_l = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_stays_empty", 64'(out_valid), 64'd0);

    // Wide instance.
    run64(4'd0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, 1'b1, "w_add");
    run64(4'd10, 64'd0, 64'd0, 64'd64, 1'b0, "w_clz0");
    run64(4'd11, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd64, 1'b0, "w_cpop");
    run64(4'd6, 64'h8000000000000000, 64'd63, 64'hFFFFFFFFFFFFFFFF, 1'b0, "w_sra");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
